pm_ladder_ctrl: RTL

Parametrised Montgomery-ladder sequencer for scalar point multiplication k·P. It is the next generation of the ladder FSM: it holds the scalar internally and finds the leading one itself, so no external key-scan handshake is needed. Key width and response timeout are parameters, and it adds an x-only mode, abort, watchdog and a status code. It sits between the top-level ECC wrapper and the axis-translate, point add/double (P_AD) and y-recovery (Mxy) datapath units, and drives the P1/P2 coordinate register loads and muxes.

---
 rtl/pm_ctrl_pkg.sv | 30 +++
 rtl/pm_msb_scan.sv | 34 +++
 rtl/pm_ladder_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pm_ctrl_pkg.sv
// Shared encodings for the Montgomery-ladder sequencer.
// State values are visible on OUT_STATE.
package pm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CHECK     = 4'd1,
    S_TRANSLATE = 4'd2,
    S_SCAN_MSB  = 4'd3,
    S_LADDER    = 4'd4,
    S_PAD_WAIT  = 4'd5,
    S_STORE     = 4'd6,
    S_Y_REC     = 4'd7,
    S_DONE      = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    ST_OK       = 3'd0,
    ST_KEY_ZERO = 3'd1,
    ST_KEY_ONE  = 3'd2,
    ST_P_INF    = 3'd3,
    ST_TIMEOUT  = 3'd4,
    ST_ABORTED  = 3'd5
  } status_e;

  localparam logic [1:0] SEL_TRANS = 2'd0;
  localparam logic [1:0] SEL_DBL   = 2'd1;
  localparam logic [1:0] SEL_ADD   = 2'd2;

endpackage

// File: rtl/pm_msb_scan.sv
// Sequential leading-one finder: one scalar bit per cycle,
// starting at the top bit and holding on the first one.
module pm_msb_scan #(
  parameter int KEY_W = 233,
  parameter int IDX_W = $clog2(KEY_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] K,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign idx   = idx_q;
  assign found = K[idx_q];

  always_comb begin
    idx_d = idx_q;
    if (start)
      idx_d = IDX_W'(KEY_W - 1);
    else if (!found && idx_q != '0)
      idx_d = idx_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

endmodule

// File: rtl/pm_ladder_ctrl.sv
// Montgomery-ladder sequencer for k*P: sequences the translate,
// add/double and y-recovery units and the P1/P2 register loads.
module pm_ladder_ctrl
  import pm_ctrl_pkg::*;
#(
  parameter int KEY_W   = 233,
  parameter int IDX_W   = $clog2(KEY_W),
  parameter int TIMEOUT = 1023
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [KEY_W-1:0] K,
  input  logic             PX_ZERO,
  input  logic             ABORT,
  input  logic             AXIS_OUT_VALID,
  input  logic             PAD_OUT_VALID,
  input  logic             MXY_OUT_VALID,
  output logic             AXIS_IN_VALID,
  output logic             PAD_IN_VALID,
  output logic             MXY_IN_VALID,
  output logic             REG_CLEAR,
  output logic             REG_LOAD,
  output logic [1:0]       SEL_P1,
  output logic [1:0]       SEL_P2,
  output logic             AD_SEL,
  output logic             BUSY,
  output logic             DONE,
  output logic [2:0]       STATUS,
  output logic [3:0]       OUT_STATE
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  status_e          stat_q, stat_d;
  logic [KEY_W-1:0] k_q;
  logic             mode_q, pxz_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             wd_exp;
  logic             ad_q, ad_d;
  logic             axis_q, axis_d;
  logic             pad_q, pad_d;
  logic             mxy_q, mxy_d;
  logic             clr_q;
  logic             ld_q, ld_d;
  logic             ld_tr, ld_pad;
  logic [1:0]       sel1_q, sel1_d;
  logic [1:0]       sel2_q, sel2_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             scan_start, scan_found;
  logic [IDX_W-1:0] scan_idx;

  pm_msb_scan #(
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_scan (
    .clk   (CLK),
    .rst   (RST),
    .start (scan_start),
    .K     (k_q),
    .idx   (scan_idx),
    .found (scan_found)
  );

  assign wd_exp     = (wd_q == WD_LAST);
  assign scan_start = (state_q == S_CHECK) &&
                      (state_d == S_TRANSLATE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    unique case (state_q)
      S_IDLE: if (START) begin
        state_d = S_CHECK;
        stat_d  = ST_OK;
      end
      S_CHECK: begin
        state_d = S_DONE;
        if (k_q == '0)                stat_d = ST_KEY_ZERO;
        else if (k_q == KEY_W'(1))    stat_d = ST_KEY_ONE;
        else if (pxz_q)               stat_d = ST_P_INF;
        else                          state_d = S_TRANSLATE;
      end
      S_TRANSLATE: begin
        if (AXIS_OUT_VALID)
          state_d = scan_found ? S_LADDER : S_SCAN_MSB;
        else if (wd_exp) begin
          state_d = S_DONE;
          stat_d  = ST_TIMEOUT;
        end
      end
      S_SCAN_MSB: if (scan_found) state_d = S_LADDER;
      S_LADDER:   state_d = S_PAD_WAIT;
      S_PAD_WAIT: begin
        if (PAD_OUT_VALID)
          state_d = S_STORE;
        else if (wd_exp) begin
          state_d = S_DONE;
          stat_d  = ST_TIMEOUT;
        end
      end
      S_STORE: begin
        if (idx_q != '0)  state_d = S_LADDER;
        else if (!mode_q) state_d = S_Y_REC;
        else begin
          state_d = S_DONE;
          stat_d  = ST_OK;
        end
      end
      S_Y_REC: begin
        if (MXY_OUT_VALID) begin
          state_d = S_DONE;
          stat_d  = ST_OK;
        end else if (wd_exp) begin
          state_d = S_DONE;
          stat_d  = ST_TIMEOUT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides any same-cycle unit response.
    if (ABORT && state_q != S_IDLE &&
        state_q != S_DONE) begin
      state_d = S_DONE;
      stat_d  = ST_ABORTED;
    end
  end

  always_comb begin
    axis_d = scan_start;
    pad_d  = (state_d == S_LADDER);
    mxy_d  = (state_q == S_STORE) &&
             (state_d == S_Y_REC);
    ld_tr  = (state_q == S_TRANSLATE) &&
             (state_d inside {S_SCAN_MSB, S_LADDER});
    ld_pad = (state_q == S_PAD_WAIT) &&
             (state_d == S_STORE);
    ld_d   = ld_tr || ld_pad;
    sel1_d = SEL_TRANS;
    sel2_d = SEL_TRANS;
    if (ld_pad) begin
      sel1_d = ad_q ? SEL_ADD : SEL_DBL;
      sel2_d = ad_q ? SEL_DBL : SEL_ADD;
    end
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
    idx_d  = idx_q;
    ad_d   = ad_q;
    // AD_SEL is set up on LADDER entry so it is valid with PAD_IN_VALID.
    if (state_d == S_LADDER) begin
      idx_d = (state_q == S_STORE) ? idx_q - 1'b1
                                   : scan_idx - 1'b1;
      ad_d  = k_q[idx_d];
    end
    wd_d = (state_d != state_q) ? '0 : wd_q + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_q <= ST_OK;
      k_q    <= '0;
      mode_q <= 1'b0;
      pxz_q  <= 1'b0;
      idx_q  <= '0;
      wd_q   <= '0;
      ad_q   <= 1'b0;
      axis_q <= 1'b0;
      pad_q  <= 1'b0;
      mxy_q  <= 1'b0;
      clr_q  <= 1'b1;
      ld_q   <= 1'b0;
      sel1_q <= SEL_TRANS;
      sel2_q <= SEL_TRANS;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && START) begin
        k_q    <= K;
        mode_q <= MODE;
        pxz_q  <= PX_ZERO;
      end
      stat_q <= stat_d;
      idx_q  <= idx_d;
      wd_q   <= wd_d;
      ad_q   <= ad_d;
      axis_q <= axis_d;
      pad_q  <= pad_d;
      mxy_q  <= mxy_d;
      clr_q  <= 1'b0;
      ld_q   <= ld_d;
      sel1_q <= sel1_d;
      sel2_q <= sel2_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign AXIS_IN_VALID = axis_q;
  assign PAD_IN_VALID  = pad_q;
  assign MXY_IN_VALID  = mxy_q;
  assign REG_CLEAR     = clr_q;
  assign REG_LOAD      = ld_q;
  assign SEL_P1        = sel1_q;
  assign SEL_P2        = sel2_q;
  assign AD_SEL        = ad_q;
  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign STATUS        = stat_q;
  assign OUT_STATE     = state_q;

endmodule
